// File: rtl/matching_pursuit_sweep_if.sv
// Start/done handshake and RAM read bus of the matching-pursuit correlation sweep.
// master = sweep engine, slave = controller and RAM side.
interface matching_pursuit_sweep_if #(
   parameter int DICT_ADDR_WIDTH = 4,
   parameter int SIG_ADDR_WIDTH  = 2,
   parameter int IDX_WIDTH       = 2
);
   // start is a request sampled only while idle (no ready: busy=1 means it is dropped);
   // done is a one-cycle valid for best_index/best_corr, which hold until the next final compare.
   logic                       start;
   logic                       done;
   logic                       busy;
   logic [DICT_ADDR_WIDTH-1:0] dict_read_addr;
   logic [31:0]                dict_read_data;
   logic [SIG_ADDR_WIDTH-1:0]  res_read_addr;
   logic [31:0]                res_read_data;
   logic [IDX_WIDTH-1:0]       best_index;
   logic [31:0]                best_corr;

   modport master (
      input  start, dict_read_data, res_read_data,
      output done, busy, dict_read_addr, res_read_addr, best_index, best_corr
   );

   modport slave (
      output start, dict_read_data, res_read_data,
      input  done, busy, dict_read_addr, res_read_addr, best_index, best_corr
   );
endinterface

// File: rtl/matching_pursuit_sweep.sv
// Correlation sweep: c_j = <r, phi_j> over all columns, reports argmax |c_j| and its signed value.
// Define MP_SWEEP_SATURATE_EN to saturate the 64->32 bit column narrowing instead of wrapping.
module matching_pursuit_sweep #(
   parameter int M               = 4,
   parameter int N               = 4,
   parameter int DICT_ADDR_WIDTH = 4,
   parameter int SIG_ADDR_WIDTH  = 2,
   parameter int IDX_WIDTH       = 2,
   parameter int FRAC_BITS       = 16
) (
   input  logic                     clock,
   input  logic                     resetN,
   matching_pursuit_sweep_if.master bus,
   output logic [1:0]               dbg_state
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_FLUSH  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   localparam logic [SIG_ADDR_WIDTH-1:0] I_LAST = SIG_ADDR_WIDTH'(M - 1);
   localparam logic [IDX_WIDTH-1:0]      J_LAST = IDX_WIDTH'(N - 1);

   typedef struct packed {
      logic                 vld;
      logic                 first;
      logic                 last;
      logic [IDX_WIDTH-1:0] col;
   } tag_t;

   logic [1:0]                 state_q, state_d;
   logic [1:0]                 flush_q, flush_d;
   logic [SIG_ADDR_WIDTH-1:0]  i_q, i_d;
   logic [IDX_WIDTH-1:0]       j_q, j_d;
   logic [DICT_ADDR_WIDTH-1:0] k_q, k_d;
   logic [DICT_ADDR_WIDTH-1:0] dict_addr_q, dict_addr_d;
   logic [SIG_ADDR_WIDTH-1:0]  res_addr_q, res_addr_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;

   tag_t                       a_tag_q, a_tag_d;
   tag_t                       b_tag_q, c_tag_q, d_tag_q;
   logic signed [63:0]         prod_q, prod_d;
   logic signed [63:0]         acc_q, acc_d;
   logic signed [63:0]         dict_ext, res_ext;

   logic [IDX_WIDTH-1:0]       best_index_q, best_index_d;
   logic [31:0]                best_corr_q, best_corr_d;
   logic [32:0]                max_q, max_d;
   logic [31:0]                corr;
   logic [32:0]                corr_ext, corr_mag;

   // Issue side: one (i, j) address pair per RUN cycle, column-major dictionary walk.
   always_comb begin
      state_d     = state_q;
      flush_d     = flush_q;
      i_d         = i_q;
      j_d         = j_q;
      k_d         = k_q;
      dict_addr_d = dict_addr_q;
      res_addr_d  = res_addr_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
            end
         end
         S_RUN: begin
            dict_addr_d = k_q;
            res_addr_d  = i_q;
            k_d         = k_q + DICT_ADDR_WIDTH'(1);
            if (i_q == I_LAST) begin
               i_d = '0;
               if (j_q == J_LAST) begin
                  state_d = S_FLUSH;
                  flush_d = '0;
               end else begin
                  j_d = j_q + IDX_WIDTH'(1);
               end
            end else begin
               i_d = i_q + SIG_ADDR_WIDTH'(1);
            end
         end
         S_FLUSH: begin
            flush_d = flush_q + 2'd1;
            if (flush_q == 2'd2) state_d = S_FINISH;
         end
         S_FINISH: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);

      a_tag_d.vld   = (state_q == S_RUN);
      a_tag_d.first = (i_q == '0);
      a_tag_d.last  = (i_q == I_LAST);
      a_tag_d.col   = j_q;
   end

   // Datapath: tags travel alongside the RAM read, the registered product and the accumulator.
   always_comb begin
      dict_ext = {{32{bus.dict_read_data[31]}}, bus.dict_read_data};
      res_ext  = {{32{bus.res_read_data[31]}}, bus.res_read_data};
      prod_d   = dict_ext * res_ext;

      acc_d = acc_q;
      if (c_tag_q.vld) begin
         acc_d = (c_tag_q.first ? 64'sd0 : acc_q) + (prod_q >>> FRAC_BITS);
      end
   end

`ifdef MP_SWEEP_SATURATE_EN
   localparam logic signed [63:0] ACC_MAX = 64'sh0000_0000_7FFF_FFFF;
   localparam logic signed [63:0] ACC_MIN = 64'shFFFF_FFFF_8000_0000;

   always_comb begin
      if (acc_q > ACC_MAX)      corr = 32'h7FFF_FFFF;
      else if (acc_q < ACC_MIN) corr = 32'h8000_0000;
      else                      corr = acc_q[31:0];
   end
`else
   always_comb begin
      corr = acc_q[31:0];
   end
`endif

   // Magnitude in 33 bits so that -2^31 maps to 2^31 without overflow.
   always_comb begin
      corr_ext     = {corr[31], corr};
      corr_mag     = corr[31] ? (~corr_ext + 33'd1) : corr_ext;
      best_index_d = best_index_q;
      best_corr_d  = best_corr_q;
      max_d        = max_q;
      if (state_q == S_IDLE && bus.start) max_d = '0;
      if (d_tag_q.vld && d_tag_q.last && (d_tag_q.col == '0 || corr_mag > max_q)) begin
         best_index_d = d_tag_q.col;
         best_corr_d  = corr;
         max_d        = corr_mag;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q      <= S_IDLE;
         flush_q      <= '0;
         i_q          <= '0;
         j_q          <= '0;
         k_q          <= '0;
         dict_addr_q  <= '0;
         res_addr_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         a_tag_q      <= '0;
         b_tag_q      <= '0;
         c_tag_q      <= '0;
         d_tag_q      <= '0;
         prod_q       <= '0;
         acc_q        <= '0;
         best_index_q <= '0;
         best_corr_q  <= '0;
         max_q        <= '0;
      end else begin
         state_q      <= state_d;
         flush_q      <= flush_d;
         i_q          <= i_d;
         j_q          <= j_d;
         k_q          <= k_d;
         dict_addr_q  <= dict_addr_d;
         res_addr_q   <= res_addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         a_tag_q      <= a_tag_d;
         b_tag_q      <= a_tag_q;
         c_tag_q      <= b_tag_q;
         d_tag_q      <= c_tag_q;
         prod_q       <= prod_d;
         acc_q        <= acc_d;
         best_index_q <= best_index_d;
         best_corr_q  <= best_corr_d;
         max_q        <= max_d;
      end
   end

   assign bus.done           = done_q;
   assign bus.busy           = busy_q;
   assign bus.dict_read_addr = dict_addr_q;
   assign bus.res_read_addr  = res_addr_q;
   assign bus.best_index     = best_index_q;
   assign bus.best_corr      = best_corr_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_matching_pursuit_sweep.sv
// Directed bench for matching_pursuit_sweep (M = N = 4) with behavioural 1-cycle RAMs.
// Expected values are hand-computed; done latency is counted in falling edges after the start edge.
module tb_matching_pursuit_sweep;

   localparam int M   = 4;
   localparam int N   = 4;
   localparam int DAW = 4;
   localparam int SAW = 2;
   localparam int IW  = 2;

   localparam logic [31:0] ONE = 32'h0001_0000;

   logic       clock  = 1'b0;
   logic       resetN = 1'b0;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] dict_mem [M*N];
   logic [31:0] res_mem  [M];

   matching_pursuit_sweep_if #(.DICT_ADDR_WIDTH(DAW), .SIG_ADDR_WIDTH(SAW), .IDX_WIDTH(IW)) bus ();

   matching_pursuit_sweep #(
      .M(M), .N(N), .DICT_ADDR_WIDTH(DAW), .SIG_ADDR_WIDTH(SAW), .IDX_WIDTH(IW), .FRAC_BITS(16)
   ) dut (
      .clock     (clock),
      .resetN    (resetN),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      bus.dict_read_data <= dict_mem[bus.dict_read_addr];
      bus.res_read_data  <= res_mem[bus.res_read_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] r3, input bit ident, input logic [31:0] fill);
      res_mem[0] = r0;
      res_mem[1] = r1;
      res_mem[2] = r2;
      res_mem[3] = r3;
      for (int j = 0; j < N; j++)
         for (int i = 0; i < M; i++)
            dict_mem[j*M + i] = ident ? ((i == j) ? ONE : 32'h0) : fill;
   endtask

   task automatic launch(input bit hold);
      @(negedge clock);
      bus.start = 1'b1;
      @(posedge clock);
      if (!hold) #1 bus.start = 1'b0;
   endtask

   // Returns the falling-edge count at which done was seen (-1 if the budget expired).
   task automatic wait_done(input int budget, input int poke_at, output int at,
                            output logic busy1, output logic busy_at_done);
      at = -1;
      busy1 = 1'bx;
      busy_at_done = 1'bx;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clock);
         if (c == 1) busy1 = bus.busy;
         if (c == poke_at) bus.start = 1'b1;
         if (c == poke_at + 1) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            at = c;
            busy_at_done = bus.busy;
            break;
         end
      end
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clock);
         if (bus.done === 1'b1) n++;
      end
   endtask

   initial begin
      int   at;
      int   n;
      logic b1;
      logic bd;

      bus.start = 1'b0;
      load(ONE, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b1, 32'h0);

      repeat (2) @(negedge clock);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_idx", bus.best_index, 0);
      chk("rst_corr", bus.best_corr, 32'h0);
      chk("rst_daddr", bus.dict_read_addr, 0);
      chk("rst_raddr", bus.res_read_addr, 0);
      chk("rst_state", dbg_state, 2'd0);
      resetN = 1'b1;

      // Case 1: ascending residual, identity dictionary.
      launch(1'b0);
      wait_done(60, -10, at, b1, bd);
      chk("c1_latency", at, 21);
      chk("c1_busy_start", b1, 1'b1);
      chk("c1_busy_done", bd, 1'b0);
      chk("c1_idx", bus.best_index, 3);
      chk("c1_corr", bus.best_corr, 32'h0004_0000);
      count_done(4, n);
      chk("c1_single_done", n, 0);
      chk("c1_daddr_hold", bus.dict_read_addr, 15);
      chk("c1_raddr_hold", bus.res_read_addr, 3);
      chk("c1_idx_hold", bus.best_index, 3);

      // Case 2: negative value wins on magnitude.
      load(32'h0, 32'hFFFB_0000, ONE, 32'h0, 1'b1, 32'h0);
      launch(1'b0);
      wait_done(60, -10, at, b1, bd);
      chk("c2_latency", at, 21);
      chk("c2_idx", bus.best_index, 1);
      chk("c2_corr", bus.best_corr, 32'hFFFB_0000);

      // Case 3: magnitude tie keeps the lower index.
      load(32'h0002_0000, 32'hFFFE_0000, 32'h0, 32'h0, 1'b1, 32'h0);
      launch(1'b0);
      wait_done(60, -10, at, b1, bd);
      chk("c3_latency", at, 21);
      chk("c3_idx", bus.best_index, 0);
      chk("c3_corr", bus.best_corr, 32'h0002_0000);

      // Case 4: large values overflow the 32-bit result.
      load(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 32'h7FFF_0000);
      launch(1'b0);
      wait_done(60, -10, at, b1, bd);
      chk("c4_latency", at, 21);
      chk("c4_idx", bus.best_index, 0);
`ifdef MP_SWEEP_SATURATE_EN
      chk("c4_corr_sat", bus.best_corr, 32'h7FFF_FFFF);
`else
      chk("c4_corr_wrap", bus.best_corr, 32'h0004_0000);
`endif

      // Case 5: start pulsed during RUN is ignored.
      load(ONE, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b1, 32'h0);
      launch(1'b0);
      wait_done(60, 5, at, b1, bd);
      chk("c5_latency", at, 21);
      count_done(25, n);
      chk("c5_no_second_done", n, 0);
      chk("c5_idx", bus.best_index, 3);
      chk("c5_corr", bus.best_corr, 32'h0004_0000);

      // Case 6: reset 6 cycles into a sweep, then a fresh sweep.
      load(32'h0, 32'hFFFB_0000, ONE, 32'h0, 1'b1, 32'h0);
      launch(1'b0);
      repeat (6) @(negedge clock);
      resetN = 1'b0;
      #1;
      chk("c6_rst_done", bus.done, 1'b0);
      chk("c6_rst_busy", bus.busy, 1'b0);
      chk("c6_rst_idx", bus.best_index, 0);
      chk("c6_rst_corr", bus.best_corr, 32'h0);
      chk("c6_rst_daddr", bus.dict_read_addr, 0);
      chk("c6_rst_raddr", bus.res_read_addr, 0);
      chk("c6_rst_state", dbg_state, 2'd0);
      @(negedge clock);
      resetN = 1'b1;
      count_done(30, n);
      chk("c6_abandoned_done", n, 0);
      load(ONE, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b1, 32'h0);
      launch(1'b0);
      wait_done(60, -10, at, b1, bd);
      chk("c6_latency", at, 21);
      chk("c6_idx", bus.best_index, 3);
      chk("c6_corr", bus.best_corr, 32'h0004_0000);

      // Case 7: start held high relaunches right after FINISH.
      load(32'h0, 32'hFFFB_0000, ONE, 32'h0, 1'b1, 32'h0);
      launch(1'b1);
      wait_done(60, -10, at, b1, bd);
      chk("c7_latency_first", at, 21);
      chk("c7_idx_first", bus.best_index, 1);
      wait_done(60, -10, at, b1, bd);
      bus.start = 1'b0;
      chk("c7_latency_second", at, 21);
      chk("c7_corr_second", bus.best_corr, 32'hFFFB_0000);
      count_done(30, n);
      chk("c7_no_third", n, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
